amba_apb_slv: RTL and testbench
===============================

AMBA_APB_SLV -- requirements
Module: amba_apb_slv

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hA000, the byte address of register 0.
REQ-002 SHALL have parameter NUM_REGS, default 8, the number of 32-bit registers (power of two, 2..16).
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, the number of PREADY-low access cycles inserted per transfer (0..15).
REQ-004 SHALL have port Pclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Prst, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port Paddr, input, 32 bits: transfer byte address.
REQ-007 SHALL have port PSELx, input, 1 bit: slave select.
REQ-008 SHALL have port P_en, input, 1 bit: PENABLE, the access-phase indicator.
REQ-009 SHALL have port P_WR, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port PWdata, input, 32 bits: write data.
REQ-011 SHALL have port PRdata, output, 32 bits: read data.
REQ-012 SHALL have port P_ready, output, 1 bit: transfer completion.
REQ-013 SHALL have port P_slverr, output, 1 bit: transfer error.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, READY, with all outputs registered.
REQ-015 IDLE: on an edge with PSELx=1 and P_en=0 (setup), SHALL latch Paddr, P_WR, PWdata and the error flag; next state READY if WAIT_CYCLES=0, else WAIT with counter = WAIT_CYCLES.
REQ-016 WAIT: SHALL decrement the counter each edge; at counter=1, next state READY.
REQ-017 Therefore P_ready SHALL be high in access cycle WAIT_CYCLES+1 after setup, for exactly one cycle; it is low in all other states.
REQ-018 READY: on the edge where PSELx=1 and P_en=1, the transfer SHALL complete (write commit, counter update) and the FSM SHALL return to IDLE.
REQ-019 Error SHALL be: address outside [BASE_ADDR, BASE_ADDR+4*NUM_REGS), Paddr[1:0]!=0, or a write to register NUM_REGS-1.
REQ-020 P_slverr SHALL equal the latched error flag while P_ready=1, and SHALL be 0 otherwise.
REQ-021 An erroring write SHALL NOT modify any register.
REQ-022 PRdata SHALL hold register[index] while P_ready=1 for a non-erroring read, and SHALL be 32'h0 in all other cycles, including error reads and writes.
REQ-023 Registers 0..NUM_REGS-2 SHALL be read/write.
REQ-024 Register NUM_REGS-1 SHALL be read-only: a 32-bit count of completed non-erroring transfers, wrapping from 32'hFFFFFFFF to 0.
REQ-025 A read of the count register SHALL return the value from before the current transfer increments it.
REQ-026 Aborted transfer: if PSELx=0 on any edge in WAIT or READY, SHALL go to IDLE with no write, no count increment and no P_ready pulse.
REQ-027 Setup-phase values SHALL be taken only from the latch; changes to Paddr, P_WR or PWdata during WAIT/READY SHALL be ignored.
REQ-028 P_en=1 with PSELx=1 seen in IDLE (protocol violation) SHALL be ignored; the FSM remains in IDLE.
REQ-029 Back-to-back transfers SHALL be supported: a setup on the cycle immediately after completion starts a new transfer.

Reset
REQ-030 When Prst=0 at an edge: FSM SHALL go to IDLE, P_ready=0, P_slverr=0, PRdata=0, all registers=0, count=0, wait counter=0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer with no register write; the first setup after reset release starts a fresh transfer.

Structure
REQ-032 Shared package amba_apb_pkg SHALL hold the state-encoding typedef, the default BASE_ADDR, and the read/write opcode constants shared with the master.
REQ-033 Register storage and the transfer counter SHALL be one sub-module, amba_apb_regfile, with a single write port and an index-addressed combinational read port.

Verification
REQ-034 Default parameters, write 32'h1234_5678 to 32'hA004, then read 32'hA004 -> P_ready high on the first access cycle, P_slverr=0, PRdata=32'h1234_5678.
REQ-035 WAIT_CYCLES=3, read 32'hA000 after reset -> P_ready low for 3 access cycles, high on the 4th, PRdata=0.
REQ-036 Write to 32'hA020 (out of range), 32'hA002 (misaligned) and 32'hA01C (read-only) -> each gives P_slverr=1 with P_ready; a subsequent read of 32'hA01C returns the completed non-error count.
REQ-037 Drop PSELx during WAIT of a write to 32'hA008 -> no P_ready pulse, and a read of 32'hA008 returns its old value.
REQ-038 Force count to 32'hFFFFFFFF, then complete one transfer -> count reads 0.
REQ-039 Assert Prst for 1 cycle mid-access -> all outputs 0 next cycle, registers cleared, next transfer completes normally.

Source files
------------

// File: rtl/amba_apb_pkg.sv
// amba_apb_pkg: state encoding, default base address and opcodes shared by the APB slave and its master
package amba_apb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, READY} apb_state_e;
  localparam logic [31:0] APB_BASE_ADDR = 32'hA000;
  localparam logic APB_READ = 1'b0;
  localparam logic APB_WRITE = 1'b1;
endpackage

// File: rtl/amba_apb_regfile.sv
// amba_apb_regfile: read/write registers plus a read-only transfer counter in the top slot
module amba_apb_regfile #(
  parameter int NUM_REGS = 8
) (
  input  logic                        Pclk,
  input  logic                        Prst,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] widx,
  input  logic [31:0]                 wdata,
  input  logic                        inc,
  input  logic [$clog2(NUM_REGS)-1:0] ridx,
  output logic [31:0]                 rdata
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);
  logic [31:0] regs [NUM_REGS];
  logic [31:0] cnt;
  always_comb rdata = ridx == LAST ? cnt : regs[ridx];
  always_ff @(posedge Pclk) begin
    if (!Prst) begin
      regs <= '{default: '0};
      cnt <= '0;
    end else begin
      if (we && widx != LAST) regs[widx] <= wdata;
      if (inc) cnt <= cnt + 32'd1;
    end
  end
endmodule

// File: rtl/amba_apb_slv.sv
// amba_apb_slv: APB slave with a register file, fixed wait states and a completed-transfer counter
module amba_apb_slv
  import amba_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = APB_BASE_ADDR,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        Pclk,
  input  logic        Prst,
  input  logic [31:0] Paddr,
  input  logic        PSELx,
  input  logic        P_en,
  input  logic        P_WR,
  input  logic [31:0] PWdata,
  output logic [31:0] PRdata,
  output logic        P_ready,
  output logic        P_slverr
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);
  localparam logic [32:0] SPAN = 33'(4 * NUM_REGS);
  apb_state_e state;
  logic [3:0] wcnt;
  logic [IW-1:0] idx, a_idx, ridx;
  logic [32:0] off;
  logic [31:0] a_wdata, rdata, r_data;
  logic err, a_err, a_wr, r_err, r_wr, done, we, inc;
  // a borrow from the subtraction lands above SPAN, so one compare covers both range ends
  always_comb begin
    off = {1'b0, Paddr} - {1'b0, BASE_ADDR};
    idx = off[IW+1:2];
    err = off >= SPAN || Paddr[1:0] != 2'b00 || (P_WR == APB_WRITE && idx == LAST);
    ridx = state == IDLE ? idx : a_idx;
    r_err = state == IDLE ? err : a_err;
    r_wr = state == IDLE ? P_WR : a_wr;
    r_data = r_err || r_wr != APB_READ ? '0 : rdata;
    done = state == READY && PSELx && P_en;
    we = done && a_wr == APB_WRITE && !a_err;
    inc = done && !a_err;
  end
  amba_apb_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
    .Pclk(Pclk), .Prst(Prst), .we(we), .widx(a_idx), .wdata(a_wdata),
    .inc(inc), .ridx(ridx), .rdata(rdata)
  );
  always_ff @(posedge Pclk) begin
    if (!Prst) begin
      state <= IDLE;
      wcnt <= '0;
      a_idx <= '0;
      a_wr <= 1'b0;
      a_err <= 1'b0;
      a_wdata <= '0;
      P_ready <= 1'b0;
      P_slverr <= 1'b0;
      PRdata <= '0;
    end else begin
      case (state)
        IDLE: if (PSELx && !P_en) begin
          a_idx <= idx;
          a_wr <= P_WR;
          a_err <= err;
          a_wdata <= PWdata;
          if (WAIT_CYCLES == 0) begin
            state <= READY;
            P_ready <= 1'b1;
            P_slverr <= r_err;
            PRdata <= r_data;
          end else begin
            state <= WAIT;
            wcnt <= 4'(WAIT_CYCLES);
          end
        end
        WAIT: if (!PSELx) begin
          state <= IDLE;
          wcnt <= '0;
        end else if (wcnt == 4'd1) begin
          state <= READY;
          wcnt <= '0;
          P_ready <= 1'b1;
          P_slverr <= r_err;
          PRdata <= r_data;
        end else begin
          wcnt <= wcnt - 4'd1;
        end
        READY: if (!PSELx || P_en) begin
          state <= IDLE;
          P_ready <= 1'b0;
          P_slverr <= 1'b0;
          PRdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_amba_apb_slv.sv
// tb_amba_apb_slv: vector table, corner sequences and random traffic on a zero-wait and a three-wait slave
module tb_amba_apb_slv;
  localparam logic [31:0] BASE = 32'hA000;
  logic Pclk, Prst;
  logic [1:0][31:0] paddr, pwdata, prdata;
  logic [1:0] psel, pen, pwr, pready, pslverr;
  int tests = 0, fails = 0;
  int lat [2] = '{1, 4};
  logic [31:0] mreg [2][8];
  logic [31:0] mcnt [2];
  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] wd;
    logic        e;
    logic [31:0] r;
  } vec_t;
  vec_t tbl [13];

  amba_apb_slv dut0 (
    .Pclk(Pclk), .Prst(Prst), .Paddr(paddr[0]), .PSELx(psel[0]), .P_en(pen[0]),
    .P_WR(pwr[0]), .PWdata(pwdata[0]), .PRdata(prdata[0]), .P_ready(pready[0]), .P_slverr(pslverr[0])
  );
  amba_apb_slv #(.WAIT_CYCLES(3)) dut1 (
    .Pclk(Pclk), .Prst(Prst), .Paddr(paddr[1]), .PSELx(psel[1]), .P_en(pen[1]),
    .P_WR(pwr[1]), .PWdata(pwdata[1]), .PRdata(prdata[1]), .P_ready(pready[1]), .P_slverr(pslverr[1])
  );

  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a, input logic w);
    return a < BASE || a >= BASE + 32 || a % 4 != 0 || (w && a == BASE + 28);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      for (int i = 0; i < 8; i++) mreg[d][i] = 0;
    end
  endtask

  task automatic idle();
    psel = '0;
    pen = '0;
  endtask

  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      output logic e_o, output logic [31:0] r_o);
    int n;
    logic exp_e;
    logic [31:0] exp_r;
    logic [2:0] ix;
    psel[d] = 1'b1; pen[d] = 1'b0; paddr[d] = a; pwr[d] = w; pwdata[d] = wd;
    exp_e = m_err(a, w);
    ix = 3'((a - BASE) / 4);
    exp_r = 0;
    if (!exp_e && !w) exp_r = ix == 3'd7 ? mcnt[d] : mreg[d][ix];
    n = 0;
    do begin
      @(negedge Pclk);
      n++;
      pen[d] = 1'b1;
      paddr[d] = $urandom;
      pwdata[d] = $urandom;
      pwr[d] = 1'($urandom);
      if (!pready[d]) chk("wait_rdata", prdata[d], 0);
    end while (!pready[d] && n < 20);
    chk("latency", n, lat[d]);
    chk("slverr", {31'b0, pslverr[d]}, {31'b0, exp_e});
    chk("rdata", prdata[d], exp_r);
    e_o = pslverr[d];
    r_o = prdata[d];
    if (!exp_e) begin
      if (w) mreg[d][ix] = wd;
      mcnt[d] = mcnt[d] + 1;
    end
    @(negedge Pclk);
    chk("pulse_end", {31'b0, pready[d]}, 0);
    chk("rdata_clr", prdata[d], 0);
  endtask

  task automatic abort_x(input int d, input logic [31:0] a, input logic [31:0] wd, input int k);
    psel[d] = 1'b1; pen[d] = 1'b0; paddr[d] = a; pwr[d] = 1'b1; pwdata[d] = wd;
    repeat (k) begin
      @(negedge Pclk);
      pen[d] = 1'b1;
      chk("abort_rdy", {31'b0, pready[d]}, 0);
    end
    psel[d] = 1'b0;
    pen[d] = 1'b0;
    repeat (2) begin
      @(negedge Pclk);
      chk("abort_idle", {31'b0, pready[d]}, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic e;
    logic [31:0] r;
    tbl[0]  = '{32'hA004, 1'b1, 32'h1234_5678, 1'b0, 32'h0};
    tbl[1]  = '{32'hA004, 1'b0, 32'h0,         1'b0, 32'h1234_5678};
    tbl[2]  = '{32'hA020, 1'b1, 32'h1111_1111, 1'b1, 32'h0};
    tbl[3]  = '{32'hA002, 1'b1, 32'h2222_2222, 1'b1, 32'h0};
    tbl[4]  = '{32'hA01C, 1'b1, 32'h3333_3333, 1'b1, 32'h0};
    tbl[5]  = '{32'hA01C, 1'b0, 32'h0,         1'b0, 32'd2};
    tbl[6]  = '{32'hA01C, 1'b0, 32'h0,         1'b0, 32'd3};
    tbl[7]  = '{32'hA000, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0};
    tbl[8]  = '{32'hA000, 1'b0, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[9]  = '{32'h9FFC, 1'b0, 32'h0,         1'b1, 32'h0};
    tbl[10] = '{32'hA018, 1'b0, 32'h0,         1'b0, 32'h0};
    tbl[11] = '{32'hA01D, 1'b0, 32'h0,         1'b1, 32'h0};
    tbl[12] = '{32'hA01C, 1'b0, 32'h0,         1'b0, 32'd7};
    paddr = '0; pwdata = '0; pwr = '0;
    idle();
    Prst = 1'b0;
    model_clear();
    repeat (2) @(negedge Pclk);
    chk("rst_ready", {30'b0, pready}, 0);
    chk("rst_slverr", {30'b0, pslverr}, 0);
    chk("rst_rdata0", prdata[0], 0);
    Prst = 1'b1;
    @(negedge Pclk);
    // table rows are issued back to back
    for (int i = 0; i < 13; i++) begin
      xfer(0, tbl[i].a, tbl[i].w, tbl[i].wd, e, r);
      chk($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].e});
      chk($sformatf("tbl%0d_rd", i), r, tbl[i].r);
    end
    idle();
    @(negedge Pclk);
    xfer(1, 32'hA000, 1'b0, 0, e, r);
    chk("w3_read0", r, 0);
    xfer(1, 32'hA008, 1'b1, 32'h55AA_55AA, e, r);
    idle();
    @(negedge Pclk);
    abort_x(1, 32'hA008, 32'h0BAD_0BAD, 2);
    xfer(1, 32'hA008, 1'b0, 0, e, r);
    chk("abort_keep", r, 32'h55AA_55AA);
    xfer(1, 32'hA01C, 1'b0, 0, e, r);
    chk("abort_cnt", r, 32'd3);
    idle();
    psel[0] = 1'b1; pen[0] = 1'b1;
    repeat (3) begin
      @(negedge Pclk);
      chk("viol_ignored", {31'b0, pready[0]}, 0);
    end
    idle();
    @(negedge Pclk);
    force dut0.u_rf.cnt = 32'hFFFF_FFFF;
    @(posedge Pclk);
    #1 release dut0.u_rf.cnt;
    mcnt[0] = 32'hFFFF_FFFF;
    @(negedge Pclk);
    xfer(0, 32'hA01C, 1'b0, 0, e, r);
    chk("cnt_max", r, 32'hFFFF_FFFF);
    xfer(0, 32'hA01C, 1'b0, 0, e, r);
    chk("cnt_wrap", r, 0);
    psel[0] = 1'b1; pen[0] = 1'b0; paddr[0] = 32'hA008; pwr[0] = 1'b1; pwdata[0] = 32'hCAFE_F00D;
    @(negedge Pclk);
    pen[0] = 1'b1;
    chk("pre_rst_ready", {31'b0, pready[0]}, 1);
    Prst = 1'b0;
    @(negedge Pclk);
    chk("mid_rst_ready", {30'b0, pready}, 0);
    chk("mid_rst_slverr", {30'b0, pslverr}, 0);
    chk("mid_rst_rdata", prdata[0], 0);
    Prst = 1'b1;
    idle();
    model_clear();
    @(negedge Pclk);
    xfer(0, 32'hA008, 1'b0, 0, e, r);
    chk("rst_no_write", r, 0);
    xfer(0, 32'hA004, 1'b0, 0, e, r);
    chk("rst_cleared", r, 0);
    xfer(0, 32'hA01C, 1'b0, 0, e, r);
    chk("rst_cnt", r, 32'd2);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = BASE - 8 + 4 * $urandom_range(0, 11);
      if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
      xfer(int'($urandom_range(0, 1)), a, 1'($urandom), $urandom, e, r);
      if ($urandom_range(0, 1) == 1) begin
        idle();
        @(negedge Pclk);
      end
    end
    idle();
    for (int d = 0; d < 2; d++) begin
      xfer(d, 32'hA01C, 1'b0, 0, e, r);
      idle();
      @(negedge Pclk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
